rr_decoder_driver: RTL
======================

Name: rr_decoder_driver

Overview:
- Round-robin arbiter that drives the 2-to-4 decoder's addr0, addr1 and enable inputs.
- Four requesters share one resource; this block picks one and emits its index as a 2-bit code plus enable. The downstream decoder expands that into a one-hot grant (out0..out3).
- Sits directly upstream of the decoder. Its outputs connect one-to-one to the decoder inputs.

Parameters:
- HOLD_MAX, 4: maximum consecutive cycles enable may stay high for one grant. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request lines; req[i] high means requester i wants the resource.
- done  input  1  the current grantee finished; sampled only while enable=1.
- addr0  output  1  LSB of the granted index; drives decoder addr0.
- addr1  output  1  MSB of the granted index; drives decoder addr1.
- enable  output  1  grant valid; drives decoder enable.
- timeout  output  1  one-cycle pulse when a grant is revoked because HOLD_MAX was hit.

Behaviour:
- All outputs are registered. No combinational path from req or done to any output.
- Reset: the following take effect on the first rising clk edge with reset=1, and hold while reset stays high.
  - addr0=0, addr1=0, enable=0, timeout=0.
  - Round-robin pointer ptr=0, hold counter cnt=0, state=IDLE.
- Index encoding: index = {addr1, addr0}.
  - 0 -> out0, 1 -> out1 (addr0=1), 2 -> out2 (addr1=1), 3 -> out3.
- States: IDLE and GRANT.
- IDLE:
  - enable=0. addr0/addr1 hold their last values.
  - If req != 0: choose the first i with req[i]=1, searching ptr, ptr+1, ... mod 4.
  - Next edge: {addr1,addr0}=i, enable=1, cnt=1, state=GRANT.
  - If req == 0: remain in IDLE.
- Latency: req asserted before edge n gives enable=1 after edge n (one cycle).
- GRANT: enable=1; addr0/addr1 are frozen.
- Release condition in GRANT, evaluated each edge. Any one of the following releases the grant:
  - (a) done=1;
  - (b) req[granted]=0;
  - (c) cnt == HOLD_MAX.
- On release:
  - enable=0 and state=IDLE.
  - ptr = granted+1 mod 4 (wraps 3 -> 0).
  - cnt=0.
  - timeout=1 for exactly one cycle only if (c) holds and neither (a) nor (b) does.
- Otherwise in GRANT: cnt increments. Result: enable is high for at most HOLD_MAX consecutive cycles.
- Mandatory gap: after any release, enable stays low for at least one cycle before the next grant.
  - Addresses may change only on the edge that raises enable. This prevents decoder output glitches between grantees.
- Simultaneous events:
  - done together with HOLD_MAX expiry: treated as done, so timeout=0.
  - Requests from other requesters during GRANT are ignored until the next IDLE.
- Reset mid-GRANT: enable drops on that edge and ptr returns to 0. No timeout pulse.
- req changes while in IDLE are sampled only at the edge; no request latching.

Test Plan:
- Reset with req=4'b1111 held: all outputs 0 while reset=1. First grant after release is index 0 (addr1=0, addr0=0, enable=1 one cycle later).
- Round-robin: req=4'b1111, done pulsed each grant → granted indices 0,1,2,3,0 in order. Each grant is followed by exactly one enable=0 cycle.
- Skip and wrap: after granting 3, req=4'b0100 → next grant is index 2 (addr1=1, addr0=0). ptr wrap from 3 to 0 is verified.
- Timeout with HOLD_MAX=4: req[1] held, done=0 → enable high exactly 4 cycles with {addr1,addr0}=01. timeout pulses one cycle on the release edge. The next grant goes to index 2 if requested, else 1 again after the gap.
- Drop request: grant to 2, then req[2] cleared in the 2nd grant cycle → enable low the following cycle, timeout=0.
- Reset mid-grant: reset asserted while enable=1 on index 3 → next edge: enable=0, addr=00. After reset releases with req=4'b1000, index 3 is granted after one cycle.

Source files
------------

// File: rtl/rr_decoder_driver.sv
// Round-robin arbiter for four requesters. Emits the granted index as a 2-bit
// code plus enable for a 2-to-4 decoder. All outputs are registered.
module rr_decoder_driver #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic       addr0,
  output logic       addr1,
  output logic       enable,
  output logic       timeout,
  output logic       dbg_state_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       enable_q, enable_d;
  logic       timeout_q, timeout_d;

  logic       pick_found;
  logic [1:0] pick_idx;
  logic       rel_done, rel_drop, rel_max;

  // First requester at or after the pointer, wrapping modulo 4.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!pick_found && req[ptr_q + 2'(k)]) begin
        pick_found = 1'b1;
        pick_idx   = ptr_q + 2'(k);
      end
    end
  end

  assign rel_done = done;
  assign rel_drop = !req[idx_q];
  assign rel_max  = (cnt_q == 8'(HOLD_MAX));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    enable_d  = enable_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        enable_d = 1'b0;
        if (pick_found) begin
          idx_d    = pick_idx;
          enable_d = 1'b1;
          cnt_d    = 8'd1;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || rel_max) begin
          // Timeout is reported only when the hold limit is the sole cause.
          enable_d  = 1'b0;
          state_d   = IDLE;
          ptr_d     = idx_q + 2'd1;
          cnt_d     = 8'd0;
          timeout_d = rel_max && !rel_done && !rel_drop;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      idx_q     <= 2'd0;
      cnt_q     <= 8'd0;
      enable_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      enable_q  <= enable_d;
      timeout_q <= timeout_d;
    end
  end

  assign addr0       = idx_q[0];
  assign addr1       = idx_q[1];
  assign enable      = enable_q;
  assign timeout     = timeout_q;
  assign dbg_state_o = state_q;

endmodule
